// File: rtl/sub_16_bit_nibble_serial.sv
// sub_16_bit_nibble_serial: sequential 16-bit subtractor, diff = a - b - bin,
// one 4-bit slice per clock, least-significant nibble first.
// Optional flags: define SUB16_FLAGS_EN to add the ovf/zero ports.
module sub_16_bit_nibble_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] diff,
  output logic        bout
`ifdef SUB16_FLAGS_EN
  ,
  output logic        ovf,
  output logic        zero
`endif
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        borrow_q, borrow_d;
  logic [11:0] shadow_q, shadow_d;
  logic [15:0] diff_q, diff_d;
  logic        bout_q, bout_d;
  logic        done_q, done_d;
`ifdef SUB16_FLAGS_EN
  logic        ovf_q, ovf_d;
  logic        zero_q, zero_d;
`endif

  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [4:0]  slice_sum;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (k_q == 2'd3) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == RUN);
  end

  // Current slice: a + ~b + ~borrow; carry-out set means no borrow
  always_comb begin
    a_nib     = a_q[{k_q, 2'b00} +: 4];
    b_nib     = b_q[{k_q, 2'b00} +: 4];
    slice_sum = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, ~borrow_q};
  end

  // Datapath next values: operand capture, slice accumulation, result publish
  always_comb begin
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    shadow_d = shadow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    done_d   = 1'b0;
`ifdef SUB16_FLAGS_EN
    ovf_d    = ovf_q;
    zero_d   = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          shadow_d = '0;
          k_d      = 2'd0;
        end
      end
      RUN: begin
        borrow_d = ~slice_sum[4];
        k_d      = k_q + 2'd1;
        // The top slice goes straight to diff, so the shadow only holds 12 bits
        case (k_q)
          2'd0: shadow_d[3:0]  = slice_sum[3:0];
          2'd1: shadow_d[7:4]  = slice_sum[3:0];
          2'd2: shadow_d[11:8] = slice_sum[3:0];
          default: begin
            diff_d = {slice_sum[3:0], shadow_q};
            bout_d = ~slice_sum[4];
            done_d = 1'b1;
`ifdef SUB16_FLAGS_EN
            ovf_d  = (a_q[15] ^ b_q[15]) & (slice_sum[3] ^ a_q[15]);
            zero_d = ({slice_sum[3:0], shadow_q} == 16'h0000);
`endif
          end
        endcase
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      shadow_q <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SUB16_FLAGS_EN
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else begin
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      shadow_q <= shadow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      done_q   <= done_d;
`ifdef SUB16_FLAGS_EN
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
`endif
    end
  end

  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SUB16_FLAGS_EN
  assign ovf  = ovf_q;
  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_sub_16_bit_nibble_serial.sv
// Directed bench for sub_16_bit_nibble_serial; checks ovf/zero when SUB16_FLAGS_EN is defined.
module tb_sub_16_bit_nibble_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        bout;
`ifdef SUB16_FLAGS_EN
  logic        ovf;
  logic        zero;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sub_16_bit_nibble_serial dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SUB16_FLAGS_EN
    ,
    .ovf   (ovf),
    .zero  (zero)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0] last_diff = '0;
  logic        last_bout = 1'b0;

  // One full operation with cycle-accurate handshake and hold checks
  task automatic do_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                       input logic vbin, input logic [15:0] ediff, input logic ebout,
                       input logic eovf, input logic ezero);
    a = va; b = vb; bin = vbin; start = 1'b1;
    tick();                                   // edge T
    start = 1'b0;
    a = ~va; b = ~vb; bin = ~vbin;            // post-accept changes must not matter
    for (int i = 0; i < 4; i++) begin
      check_eq({tag, ".busy"}, {31'd0, busy}, 32'd1);
      check_eq({tag, ".done_lo"}, {31'd0, done}, 32'd0);
      check_eq({tag, ".diff_hold"}, {16'd0, diff}, {16'd0, last_diff});
      check_eq({tag, ".bout_hold"}, {31'd0, bout}, {31'd0, last_bout});
      if (i < 3) tick();
    end
    tick();                                   // edge T+4
    check_eq({tag, ".done"}, {31'd0, done}, 32'd1);
    check_eq({tag, ".busy_lo"}, {31'd0, busy}, 32'd0);
    check_eq({tag, ".diff"}, {16'd0, diff}, {16'd0, ediff});
    check_eq({tag, ".bout"}, {31'd0, bout}, {31'd0, ebout});
`ifdef SUB16_FLAGS_EN
    check_eq({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eovf});
    check_eq({tag, ".zero"}, {31'd0, zero}, {31'd0, ezero});
`else
    if (eovf === 1'bx || ezero === 1'bx) $display("note: flag inputs undefined");
`endif
    tick();
    check_eq({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    check_eq({tag, ".diff_keep"}, {16'd0, diff}, {16'd0, ediff});
    last_diff = ediff;
    last_bout = ebout;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst.busy", {31'd0, busy}, 32'd0);
    check_eq("rst.done", {31'd0, done}, 32'd0);
    check_eq("rst.diff", {16'd0, diff}, 32'd0);
    check_eq("rst.bout", {31'd0, bout}, 32'd0);
`ifdef SUB16_FLAGS_EN
    check_eq("rst.ovf", {31'd0, ovf}, 32'd0);
    check_eq("rst.zero", {31'd0, zero}, 32'd0);
`endif
    tick();

    // Directed vectors: tag, a, b, bin, diff, bout, ovf, zero
    do_op("v1234", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    do_op("vripple", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    do_op("vbin1", 16'hFF3F, 16'h5555, 1'b1, 16'hA9E9, 1'b0, 1'b0, 1'b0);
    do_op("vbin0", 16'hFF3F, 16'h5555, 1'b0, 16'hA9EA, 1'b0, 1'b0, 1'b0);
    do_op("vovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    do_op("vzero", 16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    do_op("vovfneg", 16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    do_op("vbinonly", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    do_op("vmaxbin", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    do_op("vslice", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);

    // start re-pulsed at T+2 with new operands is ignored
    a = 16'h1234; b = 16'h0234; bin = 1'b0; start = 1'b1;
    tick();                                   // T
    start = 1'b0;
    tick();                                   // T+1
    a = 16'hFFFF; b = 16'h0000; bin = 1'b1; start = 1'b1;
    tick();                                   // T+2
    start = 1'b0;
    check_eq("repulse.busy", {31'd0, busy}, 32'd1);
    tick();                                   // T+3
    tick();                                   // T+4
    check_eq("repulse.done", {31'd0, done}, 32'd1);
    check_eq("repulse.diff", {16'd0, diff}, 32'h1000);
    check_eq("repulse.bout", {31'd0, bout}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("repulse.nodone", {30'd0, busy, done}, 32'd0);
    end

    // start held through the done cycle: second op accepted at T+5, done at T+9
    a = 16'h0010; b = 16'h0001; bin = 1'b0; start = 1'b1;
    tick();                                   // T
    a = 16'h8000; b = 16'h0001;
    tick(); tick(); tick();                   // T+3
    check_eq("held.busy_t3", {31'd0, busy}, 32'd1);
    tick();                                   // T+4
    check_eq("held.done1", {31'd0, done}, 32'd1);
    check_eq("held.diff1", {16'd0, diff}, 32'h000F);
    tick();                                   // T+5
    start = 1'b0;
    check_eq("held.busy2", {31'd0, busy}, 32'd1);
    check_eq("held.done_lo", {31'd0, done}, 32'd0);
    tick(); tick(); tick();                   // T+8
    check_eq("held.wait", {30'd0, busy, done}, 32'd2);
    check_eq("held.diff_hold", {16'd0, diff}, 32'h000F);
    tick();                                   // T+9
    check_eq("held.done2", {31'd0, done}, 32'd1);
    check_eq("held.diff2", {16'd0, diff}, 32'h7FFF);
    check_eq("held.bout2", {31'd0, bout}, 32'd0);
    tick();

    // Reset at T+2 aborts the operation
    a = 16'h0000; b = 16'h0001; bin = 1'b0; start = 1'b1;
    tick();                                   // T
    start = 1'b0;
    tick();                                   // T+1
    rst = 1'b1;
    tick();                                   // T+2 reset edge
    rst = 1'b0;
    check_eq("abort.out", {13'd0, busy, done, bout, diff}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("abort.nodone", {30'd0, busy, done}, 32'd0);
    end

    // rst and start on the same edge: start dropped
    rst = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h0001;
    tick();
    rst = 1'b0; start = 1'b0;
    check_eq("rststart.busy", {31'd0, busy}, 32'd0);
    tick();
    check_eq("rststart.idle", {30'd0, busy, done}, 32'd0);

    last_diff = 16'h0000;
    last_bout = 1'b0;
    do_op("fresh", 16'hC0DE, 16'h0ACE, 1'b1, 16'hB60F, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sub_16_bit_nibble_serial.md
# sub_16_bit_nibble_serial

Sequential 16-bit subtractor computing `a - b - bin` one 4-bit slice per clock, least-significant nibble first, with a borrow chained between slices. It is the inverse-direction companion to the team's 16-bit lookahead adders: same operand width and carry/borrow-in/out convention, with a start/done handshake. It sits beside the adders in the arithmetic unit and trades latency for area.

## Interface
- No parameters; width fixed at 16 bits, slice width fixed at 4 bits.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  16  minuend; captured at the accepting edge.
- `b`  in  16  subtrahend; captured at the accepting edge.
- `bin`  in  1  borrow-in; captured at the accepting edge.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; results valid from this cycle on.
- `diff`  out  16  result `a - b - bin` mod 2^16.
- `bout`  out  1  borrow-out; 1 iff `a < b + bin` (unsigned).
- `ovf`  out  1  signed overflow (only with `SUB16_FLAGS_EN`).
- `zero`  out  1  `diff == 0` (only with `SUB16_FLAGS_EN`).

## Operation
- FSM states: IDLE, RUN. A 2-bit slice counter `k` runs from 0 to 3 in RUN.
- IDLE, `start`=1: latch `a`, `b`, `bin`; clear the shadow result; set `k`=0; go to RUN; `busy`←1.
- RUN, each edge: compute slice `k`: `{c, d} = a[4k+3:4k] + ~b[4k+3:4k] + ~borrow`, then `borrow ← ~c`. The initial borrow is the latched `bin`. Write `d` into shadow bits `[4k+3:4k]`.
- RUN, `k`=3 edge:
  - copy the full shadow to `diff`; set `bout` ← final borrow.
  - go to IDLE; `busy`←0; `done`←1.
- `done` clears on the next edge unconditionally.
- `diff`, `bout`, `ovf` and `zero` change only on the done edge. They hold their values until the next completion or reset. Partial results are never visible.
- `start` while RUN is ignored. It is not queued, and the latched operands are not disturbed.
- Operand changes after acceptance have no effect.

## Timing
- Start accepted at edge T. Slices 0..3 are computed at edges T+1..T+4.
- At edge T+4: `done`=1, `busy`=0, results valid. Latency is 4 cycles from the accepting edge.
- The cycle in which `done`=1 is an IDLE cycle. `start`=1 here is accepted at edge T+5. Back-to-back throughput is one operation per 5 cycles.
- `busy` is 1 for exactly 4 cycles per operation.
- Reset values:
  - state IDLE, `k`=0;
  - `busy`=0, `done`=0;
  - `diff`=0x0000, `bout`=0;
  - `ovf`=0, `zero`=0.
- Reset mid-RUN aborts the operation: no `done` for the aborted operation. Outputs take their reset values on the reset edge.
- `rst` and `start` high on the same edge: reset wins; the start is dropped.

## Configuration
- `SUB16_FLAGS_EN` defined:
  - `ovf` and `zero` ports exist and are registered on the done edge.
  - `ovf = (a[15] ^ b[15]) & (diff[15] ^ a[15])`, using latched operands and the final result; `bin` is included in the result.
  - `zero = (diff == 16'h0000)`.
- Not defined: ports and their registers are absent. All other behaviour is identical.

## Test plan
- Reset, then `a`=0x1234, `b`=0x0234, `bin`=0, `start` for 1 cycle → `busy` high for 4 cycles; `done` pulse at T+4; `diff`=0x1000, `bout`=0.
- `a`=0x0000, `b`=0x0001, `bin`=0 → `diff`=0xFFFF, `bout`=1. Exercises the borrow ripple across all four slices.
- `a`=0xFF3F, `b`=0x5555, `bin`=1 → `diff`=0xA9E9, `bout`=0. Then with `bin`=0 → `diff`=0xA9EA.
- `SUB16_FLAGS_EN` on:
  - `a`=0x8000, `b`=0x0001 → `diff`=0x7FFF, `ovf`=1, `zero`=0, `bout`=0.
  - `a`=0x5555, `b`=0x5555, `bin`=0 → `diff`=0x0000, `zero`=1, `ovf`=0.
- Handshake:
  - `start` re-pulsed with new operands at T+2 → ignored; result matches the first operands.
  - `start` held high through the `done` cycle → second operation accepted at T+5, `done` at T+9.
- `rst` asserted at T+2 of an operation → no `done`; all outputs 0 next cycle. A fresh `start` then completes normally with a correct result.
